// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser.
// Back-to-back frames pop the next byte on the last stop-bit cycle, so the line never idles between them.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit, line low
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high; pops the next byte for a contiguous frame
module uart_transmit #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_Tx_DV,
  input  logic [7:0]       i_Tx_Byte,
  output logic             o_Tx_Ready,
  output logic             o_Tx_Serial,
  output logic             o_Tx_Active,
  output logic             o_Tx_Done,
  output logic [CNT_W-1:0] o_Fifo_Count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               push, pop, bit_end;

  assign o_Tx_Ready   = (count_q != CNT_FULL);
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign bit_end      = (baud_q == BAUD_LAST);
  assign pop          = (count_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d   = '0;
        serial_d = 1'b1;
        active_d = 1'b0;
        if (pop) begin
          state_d  = START;
          shift_d  = mem_q[rd_ptr_q];
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          baud_d   = '0;
          idx_d    = 3'd0;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shift_q[idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          done_d = 1'b1;
          if (pop) begin
            state_d  = START;
            shift_d  = mem_q[rd_ptr_q];
            serial_d = 1'b0;
          end else begin
            state_d  = IDLE;
            serial_d = 1'b1;
            active_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge i_CLK) begin
    if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes received bytes independently of the cycle-exact checks.
module tb_uart_transmit;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_dv = 1'b0;
  logic [7:0]    tx_byte = 8'h00;
  logic          o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic [CW-1:0] o_Fifo_Count;

  int checks = 0;
  int errors = 0;

  uart_transmit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(o_Tx_Ready), .o_Tx_Serial(o_Tx_Serial), .o_Tx_Active(o_Tx_Active),
    .o_Tx_Done(o_Tx_Done), .o_Fifo_Count(o_Fifo_Count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line monitor: detects a start bit and samples each bit mid-cell.
  logic [7:0] rx_q[$];
  logic [7:0] mon_sh;
  int         mon_cnt;
  bit         mon_busy;
  int         mon_ferr;
  initial begin
    mon_busy = 0; mon_cnt = 0; mon_ferr = 0; mon_sh = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        mon_busy = 0;
      end else if (!mon_busy) begin
        if (o_Tx_Serial === 1'b0) begin
          mon_busy = 1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
          mon_sh[(mon_cnt - 6) / 4] = o_Tx_Serial;
        if (mon_cnt == 38 && o_Tx_Serial !== 1'b1) mon_ferr++;
        if (mon_cnt == 39) begin
          rx_q.push_back(mon_sh);
          mon_busy = 0;
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tx_dv = i[0];
      tx_byte = 8'($urandom_range(0, 255));
      tick();
      checks++;
      if (o_Tx_Serial !== 1'b1 || o_Tx_Ready !== 1'b1 || o_Fifo_Count !== 3'd0 ||
          o_Tx_Active !== 1'b0 || o_Tx_Done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: serial=%b ready=%b count=%0d active=%b done=%b, want 1 1 0 0 0",
                 i, o_Tx_Serial, o_Tx_Ready, o_Fifo_Count, o_Tx_Active, o_Tx_Done);
      end
    end
    tx_dv = 1'b0;
    rst_n = 1'b1;
    tick();
    tx_byte = 8'h3C; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
    tick();
    checks++;
    if (o_Tx_Serial !== 1'b0 || o_Tx_Active !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_async: serial=%b active=%b, want 0 1", o_Tx_Serial, o_Tx_Active);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0 || o_Fifo_Count !== 3'd0 || o_Tx_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: serial=%b active=%b count=%0d ready=%b, want 1 0 0 1",
               o_Tx_Serial, o_Tx_Active, o_Fifo_Count, o_Tx_Ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [9:0] fr;
    logic       es, ea, ed;
    rx_q.delete();
    fr = {1'b1, 8'h55, 1'b0};
    tx_byte = 8'h55; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0; tx_byte = 8'hAA;
    checks++;
    if (o_Fifo_Count !== 3'd1 || o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) begin
      errors++;
      $display("FAIL single_write: count=%0d serial=%b active=%b, want 1 1 0",
               o_Fifo_Count, o_Tx_Serial, o_Tx_Active);
    end
    for (int k = 1; k <= 42; k++) begin
      tick();
      es = (k <= 40) ? fr[(k - 1) / 4] : 1'b1;
      ea = (k <= 40);
      ed = (k == 41);
      checks++;
      if (o_Tx_Serial !== es || o_Tx_Active !== ea || o_Tx_Done !== ed || o_Fifo_Count !== 3'd0) begin
        errors++;
        $display("FAIL single_cycle[%0d]: serial=%b active=%b done=%b count=%0d, want %b %b %b 0",
                 k, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count, es, ea, ed);
      end
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || mon_ferr != 0) begin
      errors++;
      $display("FAIL single_rx: got %0d bytes first=%h ferr=%0d, want 1 byte 55 ferr 0",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, mon_ferr);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bb[5];
    int         cexp[5];
    logic [9:0] fr;
    logic       es, ea, ed;
    int         dones, f, j;
    bb = '{8'hA3, 8'h0F, 8'hFF, 8'h00, 8'h81};
    cexp = '{1, 1, 2, 3, 4};
    dones = 0;
    rx_q.delete();
    for (int k = 0; k <= 201; k++) begin
      if (k < 5) begin
        tx_byte = bb[k]; tx_dv = 1'b1;
        checks++;
        if (o_Tx_Ready !== 1'b1) begin
          errors++;
          $display("FAIL burst_ready[%0d]: ready=%b, want 1", k, o_Tx_Ready);
        end
      end else begin
        tx_dv = 1'b0; tx_byte = 8'hEE;
      end
      tick();
      if (o_Tx_Done === 1'b1) dones++;
      if (k < 5) begin
        checks++;
        if (o_Fifo_Count !== CW'(cexp[k])) begin
          errors++;
          $display("FAIL burst_count[%0d]: count=%0d, want %0d", k, o_Fifo_Count, cexp[k]);
        end
      end
      if (k >= 1) begin
        if (k <= 200) begin
          f = (k - 1) / 40;
          j = (k - 1) % 40;
          fr = {1'b1, bb[f], 1'b0};
          es = fr[j / 4];
        end else begin
          es = 1'b1;
        end
        ea = (k <= 200);
        ed = (k > 1) && (((k - 1) % 40) == 0);
        checks++;
        if (o_Tx_Serial !== es || o_Tx_Active !== ea || o_Tx_Done !== ed) begin
          errors++;
          $display("FAIL burst_cycle[%0d]: serial=%b active=%b done=%b, want %b %b %b",
                   k, o_Tx_Serial, o_Tx_Active, o_Tx_Done, es, ea, ed);
        end
      end
    end
    checks++;
    if (dones != 5) begin
      errors++;
      $display("FAIL burst_dones: got %0d pulses, want 5", dones);
    end
    checks++;
    if (rx_q.size() != 5 || rx_q[0] !== 8'hA3 || rx_q[1] !== 8'h0F || rx_q[2] !== 8'hFF ||
        rx_q[3] !== 8'h00 || rx_q[4] !== 8'h81) begin
      errors++;
      $display("FAIL burst_rx: got %0d bytes, want A3 0F FF 00 81", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bb[5];
    bb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rx_q.delete();
    for (int k = 0; k < 5; k++) begin
      tx_byte = bb[k]; tx_dv = 1'b1;
      tick();
    end
    tx_byte = 8'h77; tx_dv = 1'b1;
    checks++;
    if (o_Tx_Ready !== 1'b0 || o_Fifo_Count !== 3'd4) begin
      errors++;
      $display("FAIL overflow_full: ready=%b count=%0d, want 0 4", o_Tx_Ready, o_Fifo_Count);
    end
    tick();
    tx_dv = 1'b0; tx_byte = 8'h00;
    checks++;
    if (o_Fifo_Count !== 3'd4 || o_Tx_Ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drop: count=%0d ready=%b, want 4 0", o_Fifo_Count, o_Tx_Ready);
    end
    for (int k = 0; k < 230; k++) tick();
    checks++;
    if (rx_q.size() != 5 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33 ||
        rx_q[3] !== 8'h44 || rx_q[4] !== 8'h55) begin
      errors++;
      $display("FAIL overflow_rx: got %0d bytes, want 11 22 33 44 55 only", rx_q.size());
    end
    checks++;
    if (o_Tx_Active !== 1'b0 || o_Fifo_Count !== 3'd0 || o_Tx_Serial !== 1'b1) begin
      errors++;
      $display("FAIL overflow_idle: active=%b count=%0d serial=%b, want 0 0 1",
               o_Tx_Active, o_Fifo_Count, o_Tx_Serial);
    end
  endtask

  task automatic test_simultaneous();
    rx_q.delete();
    for (int k = 0; k <= 41; k++) begin
      tx_dv = 1'b0;
      if (k == 0)  begin tx_byte = 8'h3C; tx_dv = 1'b1; end
      if (k == 1)  begin tx_byte = 8'hC5; tx_dv = 1'b1; end
      if (k == 41) begin
        tx_byte = 8'h5A; tx_dv = 1'b1;
        checks++;
        if (o_Fifo_Count !== 3'd1) begin
          errors++;
          $display("FAIL simul_pre: count=%0d, want 1", o_Fifo_Count);
        end
      end
      tick();
    end
    tx_dv = 1'b0; tx_byte = 8'h00;
    checks++;
    if (o_Fifo_Count !== 3'd1 || o_Tx_Done !== 1'b1 || o_Tx_Serial !== 1'b0 || o_Tx_Active !== 1'b1) begin
      errors++;
      $display("FAIL simul_edge: count=%0d done=%b serial=%b active=%b, want 1 1 0 1",
               o_Fifo_Count, o_Tx_Done, o_Tx_Serial, o_Tx_Active);
    end
    for (int k = 0; k < 100; k++) tick();
    checks++;
    if (rx_q.size() != 3 || rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC5 || rx_q[2] !== 8'h5A) begin
      errors++;
      $display("FAIL simul_rx: got %0d bytes, want 3C C5 5A", rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    rx_q.delete();
    for (int k = 0; k <= 18; k++) begin
      tx_dv = 1'b0;
      if (k == 0) begin tx_byte = 8'hF4; tx_dv = 1'b1; end
      if (k == 1) begin tx_byte = 8'h0B; tx_dv = 1'b1; end
      if (k == 2) begin tx_byte = 8'h0C; tx_dv = 1'b1; end
      tick();
    end
    tx_dv = 1'b0;
    checks++;
    if (o_Tx_Serial !== 1'b0 || o_Fifo_Count !== 3'd2 || o_Tx_Active !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: serial=%b count=%0d active=%b, want 0 2 1",
               o_Tx_Serial, o_Fifo_Count, o_Tx_Active);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_Tx_Serial !== 1'b1 || o_Fifo_Count !== 3'd0 || o_Tx_Active !== 1'b0 || o_Tx_Ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: serial=%b count=%0d active=%b ready=%b, want 1 0 0 1",
               o_Tx_Serial, o_Fifo_Count, o_Tx_Active, o_Tx_Ready);
    end
    tick(); tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: %0d busy cycles, %0d bytes seen, want 0 0", bad, rx_q.size());
    end
    tx_byte = 8'h96; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
    for (int k = 0; k < 45; k++) tick();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin
      errors++;
      $display("FAIL rstmid_after: got %0d bytes, want single 96", rx_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (mon_ferr != 0) begin
      errors++;
      $display("FAIL framing: %0d stop-bit errors, want 0", mon_ferr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
